// File: rtl/icache_fill_ctrl.sv
// icache_fill_ctrl
//   Instruction-cache fill and flush sequencer. It accepts one miss or one
//   invalidate-all request at a time. A miss issues a memory fetch for
//   {tag, set}, waits for the line to land, and then writes the tag and status
//   arrays for the victim way. A flush sweeps every set and clears the status
//   of all ways.
//
// Ports
//   clk, arst                 clock, asynchronous active-high reset
//   i_halt                    freezes state; requests, strobes and pulses are 0
//   i_miss_*/o_miss_ready     miss request handshake (set, tag, victim way)
//   i_flush_valid/o_flush_ready  invalidate-all handshake
//   o_mem_req_*/i_mem_req_ready  fetch request; i_mem_resp_valid = fill landed
//   o_w_ta_*                  tag array write port
//   o_w_sa_*                  status array write port
//   i_arr_ready               both array write ports can accept this cycle
//   o_busy                    not idle
//   o_fill_done/o_flush_done  one-cycle retire pulses
module icache_fill_ctrl #(
  parameter int SET_BITS_WIDTH = 4,
  parameter int TAG_WIDTH      = 8,
  parameter int NUM_WAYS       = 4
) (
  input  logic                          clk,
  input  logic                          arst,
  input  logic                          i_halt,
  input  logic                          i_miss_valid,
  input  logic [SET_BITS_WIDTH-1:0]     i_miss_set_addr,
  input  logic [TAG_WIDTH-1:0]          i_miss_tag,
  input  logic [1:0]                    i_miss_way,
  output logic                          o_miss_ready,
  input  logic                          i_flush_valid,
  output logic                          o_flush_ready,
  output logic                          o_mem_req_valid,
  output logic [TAG_WIDTH+SET_BITS_WIDTH-1:0] o_mem_req_addr,
  input  logic                          i_mem_req_ready,
  input  logic                          i_mem_resp_valid,
  output logic [SET_BITS_WIDTH-1:0]     o_w_ta_set_addr,
  output logic [TAG_WIDTH*NUM_WAYS-1:0] o_w_ta_data,
  output logic [NUM_WAYS-1:0]           o_w_ta_mask,
  output logic                          o_w_ta_valid,
  output logic [SET_BITS_WIDTH-1:0]     o_w_sa_set_addr,
  output logic [2*NUM_WAYS-1:0]         o_w_sa_data,
  output logic [NUM_WAYS-1:0]           o_w_sa_mask,
  output logic                          o_w_sa_valid,
  input  logic                          i_arr_ready,
  output logic                          o_busy,
  output logic                          o_fill_done,
  output logic                          o_flush_done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MREQ  = 3'd1,
    S_MWAIT = 3'd2,
    S_WRITE = 3'd3,
    S_FLUSH = 3'd4
  } state_t;

  state_t                    state_q, state_d;
  logic [SET_BITS_WIDTH-1:0] set_q, set_d;
  logic [TAG_WIDTH-1:0]      tag_q, tag_d;
  logic [1:0]                way_q, way_d;
  logic [SET_BITS_WIDTH-1:0] cnt_q, cnt_d;

  // Per-way replicated tag and one-hot victim mask.
  logic [TAG_WIDTH*NUM_WAYS-1:0] tag_rep;
  logic [NUM_WAYS-1:0]           way_oh;

  for (genvar g = 0; g < NUM_WAYS; g++) begin : g_way
    assign tag_rep[g*TAG_WIDTH +: TAG_WIDTH] = tag_q;
    assign way_oh[g] = (way_q == 2'(g));
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= S_IDLE;
      set_q   <= '0;
      tag_q   <= '0;
      way_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      set_q   <= set_d;
      tag_q   <= tag_d;
      way_q   <= way_d;
      cnt_q   <= cnt_d;
    end
  end

  // Handshake readies are forced high while reset is asserted so upstream
  // sees an idle, accepting controller; the state flops cannot move then.
  always_comb begin
    o_busy        = (state_q != S_IDLE);
    o_flush_ready = arst | ((state_q == S_IDLE) & ~i_halt);
    o_miss_ready  = arst | ((state_q == S_IDLE) & ~i_halt & ~i_flush_valid);
  end

  always_comb begin
    state_d         = state_q;
    set_d           = set_q;
    tag_d           = tag_q;
    way_d           = way_q;
    cnt_d           = cnt_q;
    o_mem_req_valid = 1'b0;
    o_mem_req_addr  = '0;
    o_w_ta_set_addr = '0;
    o_w_ta_data     = '0;
    o_w_ta_mask     = '0;
    o_w_ta_valid    = 1'b0;
    o_w_sa_set_addr = '0;
    o_w_sa_data     = '0;
    o_w_sa_mask     = '0;
    o_w_sa_valid    = 1'b0;
    o_fill_done     = 1'b0;
    o_flush_done    = 1'b0;

    // Halt gates every branch: nothing advances and nothing is emitted.
    if (!i_halt) begin
      unique case (state_q)
        S_IDLE: begin
          if (i_flush_valid) begin
            cnt_d   = '0;
            state_d = S_FLUSH;
          end else if (i_miss_valid) begin
            set_d   = i_miss_set_addr;
            tag_d   = i_miss_tag;
            way_d   = i_miss_way;
            state_d = S_MREQ;
          end
        end
        S_MREQ: begin
          o_mem_req_valid = 1'b1;
          o_mem_req_addr  = {tag_q, set_q};
          if (i_mem_req_ready) state_d = S_MWAIT;
        end
        S_MWAIT: begin
          if (i_mem_resp_valid) state_d = S_WRITE;
        end
        S_WRITE: begin
          o_w_ta_valid    = 1'b1;
          o_w_ta_set_addr = set_q;
          o_w_ta_data     = tag_rep;
          o_w_ta_mask     = way_oh;
          o_w_sa_valid    = 1'b1;
          o_w_sa_set_addr = set_q;
          o_w_sa_data     = {NUM_WAYS{2'b01}};
          o_w_sa_mask     = way_oh;
          if (i_arr_ready) begin
            o_fill_done = 1'b1;
            state_d     = S_IDLE;
          end
        end
        S_FLUSH: begin
          o_w_sa_valid    = 1'b1;
          o_w_sa_set_addr = cnt_q;
          o_w_sa_mask     = '1;
          if (i_arr_ready) begin
            // Counter wraps to 0 naturally after the last set.
            cnt_d = cnt_q + SET_BITS_WIDTH'(1);
            if (cnt_q == '1) begin
              o_flush_done = 1'b1;
              state_d      = S_IDLE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_fill_ctrl.sv
module tb_icache_fill_ctrl;

  logic        clk, arst, i_halt;
  logic        i_miss_valid;
  logic [3:0]  i_miss_set_addr;
  logic [7:0]  i_miss_tag;
  logic [1:0]  i_miss_way;
  logic        o_miss_ready, i_flush_valid, o_flush_ready;
  logic        o_mem_req_valid;
  logic [11:0] o_mem_req_addr;
  logic        i_mem_req_ready, i_mem_resp_valid;
  logic [3:0]  o_w_ta_set_addr;
  logic [31:0] o_w_ta_data;
  logic [3:0]  o_w_ta_mask;
  logic        o_w_ta_valid;
  logic [3:0]  o_w_sa_set_addr;
  logic [7:0]  o_w_sa_data;
  logic [3:0]  o_w_sa_mask;
  logic        o_w_sa_valid, i_arr_ready, o_busy, o_fill_done, o_flush_done;

  int checks = 0;
  int errors = 0;

  icache_fill_ctrl #(.SET_BITS_WIDTH(4), .TAG_WIDTH(8), .NUM_WAYS(4)) dut (
    .clk(clk), .arst(arst), .i_halt(i_halt),
    .i_miss_valid(i_miss_valid), .i_miss_set_addr(i_miss_set_addr),
    .i_miss_tag(i_miss_tag), .i_miss_way(i_miss_way), .o_miss_ready(o_miss_ready),
    .i_flush_valid(i_flush_valid), .o_flush_ready(o_flush_ready),
    .o_mem_req_valid(o_mem_req_valid), .o_mem_req_addr(o_mem_req_addr),
    .i_mem_req_ready(i_mem_req_ready), .i_mem_resp_valid(i_mem_resp_valid),
    .o_w_ta_set_addr(o_w_ta_set_addr), .o_w_ta_data(o_w_ta_data),
    .o_w_ta_mask(o_w_ta_mask), .o_w_ta_valid(o_w_ta_valid),
    .o_w_sa_set_addr(o_w_sa_set_addr), .o_w_sa_data(o_w_sa_data),
    .o_w_sa_mask(o_w_sa_mask), .o_w_sa_valid(o_w_sa_valid),
    .i_arr_ready(i_arr_ready), .o_busy(o_busy),
    .o_fill_done(o_fill_done), .o_flush_done(o_flush_done)
  );

  // Control view: {miss_rdy, flush_rdy, mem_vld, ta_vld, sa_vld, busy, fill_done, flush_done}
  logic [7:0]  ctl;
  // Array write payload: {ta_set, ta_data, ta_mask, sa_set, sa_data, sa_mask}
  logic [55:0] wpay;
  assign ctl  = {o_miss_ready, o_flush_ready, o_mem_req_valid, o_w_ta_valid,
                 o_w_sa_valid, o_busy, o_fill_done, o_flush_done};
  assign wpay = {o_w_ta_set_addr, o_w_ta_data, o_w_ta_mask,
                 o_w_sa_set_addr, o_w_sa_data, o_w_sa_mask};

  localparam logic [7:0] C_IDLE  = 8'b1100_0000;
  localparam logic [7:0] C_IDLEF = 8'b0100_0000;
  localparam logic [7:0] C_MREQ  = 8'b0010_0100;
  localparam logic [7:0] C_BUSY  = 8'b0000_0100;
  localparam logic [7:0] C_WR    = 8'b0001_1110;
  localparam logic [7:0] C_WRST  = 8'b0001_1100;
  localparam logic [7:0] C_FL    = 8'b0000_1100;
  localparam logic [7:0] C_FLD   = 8'b0000_1101;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

  task automatic test_reset();
    arst = 1'b1; i_halt = 1'b0; i_miss_valid = 1'b0; i_miss_set_addr = '0;
    i_miss_tag = '0; i_miss_way = '0; i_flush_valid = 1'b1;
    i_mem_req_ready = 1'b0; i_mem_resp_valid = 1'b0; i_arr_ready = 1'b0;
    @(negedge clk); #1;
    checks++; if (ctl !== C_IDLE) begin errors++; $display("FAIL rst_ctl got %b exp %b", ctl, C_IDLE); end
    checks++; if (wpay !== 56'h0 || o_mem_req_addr !== 12'h0) begin errors++;
      $display("FAIL rst_data got %h/%h exp 0", wpay, o_mem_req_addr); end
    @(negedge clk); arst = 1'b0; i_flush_valid = 1'b0; #1;
    checks++; if (ctl !== C_IDLE) begin errors++; $display("FAIL idle_ctl got %b exp %b", ctl, C_IDLE); end
    i_halt = 1'b1; #1;
    checks++; if (ctl !== 8'h00) begin errors++; $display("FAIL idle_halt got %b exp %b", ctl, 8'h00); end
    i_halt = 1'b0;
  endtask

  task automatic test_miss();
    logic [55:0] ep;
    ep = {4'h5, 32'hA3A3A3A3, 4'b0100, 4'h5, 8'h55, 4'b0100};
    @(negedge clk); i_miss_valid = 1'b1; i_miss_set_addr = 4'd5; i_miss_tag = 8'hA3; i_miss_way = 2'd2; #1;
    checks++; if (ctl !== C_IDLE) begin errors++; $display("FAIL miss_acc got %b exp %b", ctl, C_IDLE); end
    @(negedge clk); i_miss_valid = 1'b0; i_miss_tag = 8'h00; i_miss_set_addr = 4'h0; #1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin @(negedge clk); #1; end
      if (i == 3) begin i_mem_req_ready = 1'b1; #1; end
      checks++; if (ctl !== C_MREQ || o_mem_req_addr !== 12'hA35 || wpay !== 56'h0) begin errors++;
        $display("FAIL mreq%0d got %b/%h exp %b/%h", i, ctl, o_mem_req_addr, C_MREQ, 12'hA35); end
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); i_mem_req_ready = 1'b0; i_mem_resp_valid = (i == 3); #1;
      checks++; if (ctl !== C_BUSY || wpay !== 56'h0) begin errors++;
        $display("FAIL mwait%0d got %b exp %b", i, ctl, C_BUSY); end
    end
    @(negedge clk); i_mem_resp_valid = 1'b0; i_arr_ready = 1'b1; #1;
    checks++; if (ctl !== C_WR) begin errors++; $display("FAIL write_ctl got %b exp %b", ctl, C_WR); end
    checks++; if (wpay !== ep) begin errors++; $display("FAIL write_pay got %h exp %h", wpay, ep); end
    @(negedge clk); i_arr_ready = 1'b0; #1;
    checks++; if (ctl !== C_IDLE || wpay !== 56'h0) begin errors++;
      $display("FAIL miss_after got %b exp %b", ctl, C_IDLE); end
  endtask

  task automatic test_flush();
    logic [7:0]  ec;
    logic [55:0] ep;
    @(negedge clk); i_flush_valid = 1'b1; i_arr_ready = 1'b1; #1;
    checks++; if (ctl !== C_IDLEF) begin errors++; $display("FAIL flush_acc got %b exp %b", ctl, C_IDLEF); end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); i_flush_valid = 1'b0; #1;
      ec = (i == 15) ? C_FLD : C_FL;
      ep = {4'h0, 32'h0, 4'h0, 4'(i), 8'h00, 4'hF};
      checks++; if (ctl !== ec || wpay !== ep) begin errors++;
        $display("FAIL flush_set%0d got %b/%h exp %b/%h", i, ctl, wpay, ec, ep); end
    end
    @(negedge clk); i_arr_ready = 1'b0; #1;
    checks++; if (ctl !== C_IDLE) begin errors++; $display("FAIL flush_after got %b exp %b", ctl, C_IDLE); end
  endtask

  task automatic test_priority();
    logic [7:0]  ec;
    logic [55:0] ep;
    ep = {4'h3, 32'h5C5C5C5C, 4'b0010, 4'h3, 8'h55, 4'b0010};
    @(negedge clk); i_flush_valid = 1'b1; i_miss_valid = 1'b1; i_miss_set_addr = 4'd3;
    i_miss_tag = 8'h5C; i_miss_way = 2'd1; i_arr_ready = 1'b1; #1;
    checks++; if (ctl !== C_IDLEF) begin errors++; $display("FAIL prio_acc got %b exp %b", ctl, C_IDLEF); end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); i_flush_valid = 1'b0; #1;
      ec = (i == 15) ? C_FLD : C_FL;
      checks++; if (ctl !== ec) begin errors++; $display("FAIL prio_fl%0d got %b exp %b", i, ctl, ec); end
    end
    @(negedge clk); #1;
    checks++; if (ctl !== C_IDLE) begin errors++; $display("FAIL prio_miss_acc got %b exp %b", ctl, C_IDLE); end
    @(negedge clk); i_miss_valid = 1'b0; i_mem_req_ready = 1'b1; #1;
    checks++; if (ctl !== C_MREQ || o_mem_req_addr !== 12'h5C3) begin errors++;
      $display("FAIL prio_mreq got %b/%h exp %b/%h", ctl, o_mem_req_addr, C_MREQ, 12'h5C3); end
    @(negedge clk); i_mem_req_ready = 1'b0; i_mem_resp_valid = 1'b1; #1;
    checks++; if (ctl !== C_BUSY) begin errors++; $display("FAIL prio_mwait got %b exp %b", ctl, C_BUSY); end
    @(negedge clk); i_mem_resp_valid = 1'b0; #1;
    checks++; if (ctl !== C_WR || wpay !== ep) begin errors++;
      $display("FAIL prio_write got %b/%h exp %b/%h", ctl, wpay, C_WR, ep); end
    @(negedge clk); i_arr_ready = 1'b0; #1;
    checks++; if (ctl !== C_IDLE) begin errors++; $display("FAIL prio_after got %b exp %b", ctl, C_IDLE); end
  endtask

  task automatic test_stall_halt();
    logic [55:0] ep, efp;
    logic [7:0]  ec;
    int exp_set, hc, cyc;
    ep = {4'hA, 32'h11111111, 4'b1000, 4'hA, 8'h55, 4'b1000};
    @(negedge clk); i_miss_valid = 1'b1; i_miss_set_addr = 4'hA; i_miss_tag = 8'h11;
    i_miss_way = 2'd3; i_mem_req_ready = 1'b1; #1;
    @(negedge clk); i_miss_valid = 1'b0; #1;
    checks++; if (ctl !== C_MREQ || o_mem_req_addr !== 12'h11A) begin errors++;
      $display("FAIL st_mreq got %b/%h exp %b/%h", ctl, o_mem_req_addr, C_MREQ, 12'h11A); end
    @(negedge clk); i_mem_req_ready = 1'b0; i_mem_resp_valid = 1'b1; #1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); i_mem_resp_valid = 1'b0; i_arr_ready = (i == 3); #1;
      ec = (i == 3) ? C_WR : C_WRST;
      checks++; if (ctl !== ec || wpay !== ep) begin errors++;
        $display("FAIL st_write%0d got %b/%h exp %b/%h", i, ctl, wpay, ec, ep); end
    end
    @(negedge clk); i_flush_valid = 1'b1; i_arr_ready = 1'b1; #1;
    checks++; if (ctl !== C_IDLEF) begin errors++; $display("FAIL st_flacc got %b exp %b", ctl, C_IDLEF); end
    exp_set = 0; hc = 0; cyc = 0;
    while (exp_set < 16 && cyc < 40) begin
      @(negedge clk); i_flush_valid = 1'b0;
      i_halt = (exp_set == 7 && hc < 2);
      #1; cyc++;
      if (i_halt) begin
        hc++;
        checks++; if (ctl !== C_BUSY || wpay !== 56'h0) begin errors++;
          $display("FAIL st_halt%0d got %b/%h exp %b/0", hc, ctl, wpay, C_BUSY); end
      end else begin
        ec  = (exp_set == 15) ? C_FLD : C_FL;
        efp = {4'h0, 32'h0, 4'h0, 4'(exp_set), 8'h00, 4'hF};
        checks++; if (ctl !== ec || wpay !== efp) begin errors++;
          $display("FAIL st_fl%0d got %b/%h exp %b/%h", exp_set, ctl, wpay, ec, efp); end
        exp_set++;
      end
    end
    i_halt = 1'b0;
    @(negedge clk); i_arr_ready = 1'b0; #1;
    checks++; if (ctl !== C_IDLE) begin errors++; $display("FAIL st_after got %b exp %b", ctl, C_IDLE); end
  endtask

  task automatic test_resp_reset();
    @(negedge clk); i_miss_valid = 1'b1; i_miss_set_addr = 4'h1; i_miss_tag = 8'h22; i_miss_way = 2'd0; #1;
    @(negedge clk); i_miss_valid = 1'b0; i_mem_resp_valid = 1'b1; #1;
    checks++; if (ctl !== C_MREQ || o_mem_req_addr !== 12'h221) begin errors++;
      $display("FAIL rr_mreq got %b/%h exp %b/%h", ctl, o_mem_req_addr, C_MREQ, 12'h221); end
    @(negedge clk); i_mem_resp_valid = 1'b0; i_halt = 1'b1; i_mem_req_ready = 1'b1; #1;
    checks++; if (ctl !== C_BUSY) begin errors++; $display("FAIL rr_halt got %b exp %b", ctl, C_BUSY); end
    @(negedge clk); i_halt = 1'b0; i_mem_req_ready = 1'b0; #1;
    checks++; if (ctl !== C_MREQ || o_mem_req_addr !== 12'h221) begin errors++;
      $display("FAIL rr_still_mreq got %b/%h exp %b/%h", ctl, o_mem_req_addr, C_MREQ, 12'h221); end
    @(negedge clk); i_mem_req_ready = 1'b1; #1;
    @(negedge clk); i_mem_req_ready = 1'b0; #1;
    checks++; if (ctl !== C_BUSY) begin errors++; $display("FAIL rr_mwait got %b exp %b", ctl, C_BUSY); end
    @(negedge clk); arst = 1'b1; i_mem_resp_valid = 1'b1; i_arr_ready = 1'b1; #1;
    checks++; if (ctl !== C_IDLE || wpay !== 56'h0) begin errors++;
      $display("FAIL rr_arst got %b/%h exp %b/0", ctl, wpay, C_IDLE); end
    @(negedge clk); #1;
    checks++; if (ctl !== C_IDLE || wpay !== 56'h0) begin errors++;
      $display("FAIL rr_arst_hold got %b/%h exp %b/0", ctl, wpay, C_IDLE); end
    @(negedge clk); arst = 1'b0; i_mem_resp_valid = 1'b0; #1;
    @(negedge clk); #1;
    checks++; if (ctl !== C_IDLE || wpay !== 56'h0) begin errors++;
      $display("FAIL rr_post got %b/%h exp %b/0", ctl, wpay, C_IDLE); end
    i_arr_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_miss();
    test_flush();
    test_priority();
    test_stall_halt();
    test_resp_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
